ctrl_pipe_dew: RTL and testbench

Control-signal pipeline carrying decoded control from the decode stage through execute, memory and writeback of the 5-stage RV32I core. Registers the decode controller outputs into E/M/W stages with per-stage valid bits. Resolves branch/jump redirection in E. Counts retired instructions in W. Sits directly downstream of the decode controller; its staged register addresses feed the hazard unit.

---
 rtl/ctrl_pipe_dew.sv | 120 ++++++++++++
 tb/tb_ctrl_pipe_dew.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe_dew.sv
// Decoded-control pipeline for the 5-stage RV32I core: D->E->M->W registers with
// per-stage valid bits, E-stage branch/jump resolution and a W-stage retire counter.
module ctrl_pipe_dew #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ValidD,
  input  logic             FlushE,
  input  logic [1:0]       ResultSrcD,
  input  logic             MemWriteD,
  input  logic [2:0]       ALUControlD,
  input  logic             ALUSrcD,
  input  logic             RegWriteD,
  input  logic [1:0]       BranchD,
  input  logic             JumpD,
  input  logic             sel_adderD,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdD,
  input  logic             ZeroE,
  output logic [2:0]       ALUControlE,
  output logic [1:0]       ResultSrcE,
  output logic             ALUSrcE,
  output logic             sel_adderE,
  output logic [4:0]       Rs1E,
  output logic [4:0]       Rs2E,
  output logic [4:0]       RdE,
  output logic             PCSrcE,
  output logic             RegWriteM,
  output logic             MemWriteM,
  output logic [1:0]       ResultSrcM,
  output logic [4:0]       RdM,
  output logic             RegWriteW,
  output logic [1:0]       ResultSrcW,
  output logic [4:0]       RdW,
  output logic             ValidE,
  output logic             ValidM,
  output logic             ValidW,
  output logic [CNT_W-1:0] InstRet
);

  logic       RegWriteE;
  logic       MemWriteE;
  logic       JumpE;
  logic [1:0] BranchE;

  // Reset and flush both leave E as a full bubble, so they share one branch.
  always_ff @(posedge clk) begin
    if (rst || FlushE) begin
      ValidE      <= 1'b0;
      RegWriteE   <= 1'b0;
      MemWriteE   <= 1'b0;
      BranchE     <= 2'b00;
      JumpE       <= 1'b0;
      ResultSrcE  <= 2'b00;
      ALUControlE <= 3'b000;
      ALUSrcE     <= 1'b0;
      sel_adderE  <= 1'b0;
      Rs1E        <= 5'd0;
      Rs2E        <= 5'd0;
      RdE         <= 5'd0;
    end else begin
      ValidE      <= ValidD;
      RegWriteE   <= RegWriteD & ValidD;
      MemWriteE   <= MemWriteD & ValidD;
      BranchE     <= ValidD ? BranchD : 2'b00;
      JumpE       <= JumpD & ValidD;
      ResultSrcE  <= ResultSrcD;
      ALUControlE <= ALUControlD;
      ALUSrcE     <= ALUSrcD;
      sel_adderE  <= sel_adderD;
      Rs1E        <= Rs1D;
      Rs2E        <= Rs2D;
      RdE         <= RdD;
    end
  end

  assign PCSrcE = ValidE & (JumpE | ((BranchE == 2'b01) & ZeroE) |
                            ((BranchE == 2'b10) & ~ZeroE));

  always_ff @(posedge clk) begin
    if (rst) begin
      ValidM     <= 1'b0;
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= 2'b00;
      RdM        <= 5'd0;
    end else begin
      ValidM     <= ValidE;
      RegWriteM  <= RegWriteE;
      MemWriteM  <= MemWriteE;
      ResultSrcM <= ResultSrcE;
      RdM        <= RdE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ValidW     <= 1'b0;
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
      RdW        <= 5'd0;
    end else begin
      ValidW     <= ValidM;
      RegWriteW  <= RegWriteM;
      ResultSrcW <= ResultSrcM;
      RdW        <= RdM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      InstRet <= '0;
    end else if (ValidW) begin
      InstRet <= InstRet + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ctrl_pipe_dew.sv
// Bench for ctrl_pipe_dew: a table of D-stage instructions whose expected E/M/W
// views are queued when driven and popped as each stage presents them.
module tb_ctrl_pipe_dew;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst, ValidD, FlushE, MemWriteD, ALUSrcD, RegWriteD, JumpD, sel_adderD, ZeroE;
  logic [1:0] ResultSrcD, BranchD;
  logic [2:0] ALUControlD;
  logic [4:0] Rs1D, Rs2D, RdD;
  logic [2:0] ALUControlE;
  logic [1:0] ResultSrcE, ResultSrcM, ResultSrcW;
  logic ALUSrcE, sel_adderE, PCSrcE, RegWriteM, MemWriteM, RegWriteW, ValidE, ValidM, ValidW;
  logic [4:0] Rs1E, Rs2E, RdE, RdM, RdW;
  logic [CNT_W-1:0] InstRet;

  always #5 clk = ~clk;

  ctrl_pipe_dew #(.CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst), .ValidD(ValidD), .FlushE(FlushE), .ResultSrcD(ResultSrcD),
    .MemWriteD(MemWriteD), .ALUControlD(ALUControlD), .ALUSrcD(ALUSrcD),
    .RegWriteD(RegWriteD), .BranchD(BranchD), .JumpD(JumpD), .sel_adderD(sel_adderD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ZeroE(ZeroE),
    .ALUControlE(ALUControlE), .ResultSrcE(ResultSrcE), .ALUSrcE(ALUSrcE),
    .sel_adderE(sel_adderE), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .PCSrcE(PCSrcE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .RdM(RdM),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RdW(RdW),
    .ValidE(ValidE), .ValidM(ValidM), .ValidW(ValidW), .InstRet(InstRet)
  );

  typedef struct {
    logic       v, f, rw, mw, j, z, pc;
    logic [1:0] rs, br;
    logic [2:0] alu;
    logic [4:0] rd;
  } vec_t;

  typedef struct {
    logic       ev, erw, emw, z, pc, as, sa;
    logic [1:0] rs;
    logic [2:0] alu;
    logic [4:0] rs1, rs2, rd;
  } exp_t;

  vec_t tbl[17];
  exp_t qE[$], qM[$], qW[$];
  int   n_chk = 0, n_pass = 0, exp_cnt = 0;
  logic last_wv = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  function automatic vec_t mkv(input int v, f, rw, mw, rs, alu, br, j, rd, z, pc);
    vec_t t;
    t.v = v[0]; t.f = f[0]; t.rw = rw[0]; t.mw = mw[0]; t.rs = rs[1:0]; t.alu = alu[2:0];
    t.br = br[1:0]; t.j = j[0]; t.rd = rd[4:0]; t.z = z[0]; t.pc = pc[0];
    return t;
  endfunction

  // Expected view of an instruction once it is in E; flushed entries are all-zero.
  function automatic exp_t mk(input vec_t d);
    exp_t e;
    e.ev  = d.v & ~d.f;
    e.erw = d.rw & e.ev;
    e.emw = d.mw & e.ev;
    e.z   = d.z;
    e.pc  = d.pc;
    e.as  = d.f ? 1'b0 : d.rd[0];
    e.sa  = d.f ? 1'b0 : d.j;
    e.rs  = d.f ? 2'd0 : d.rs;
    e.alu = d.f ? 3'd0 : d.alu;
    e.rs1 = d.f ? 5'd0 : d.rd + 5'd10;
    e.rs2 = d.f ? 5'd0 : d.rd + 5'd20;
    e.rd  = d.f ? 5'd0 : d.rd;
    return e;
  endfunction

  task automatic cycle(input vec_t d);
    exp_t e, m, w;
    ValidD = d.v; FlushE = d.f; RegWriteD = d.rw; MemWriteD = d.mw; ResultSrcD = d.rs;
    ALUControlD = d.alu; BranchD = d.br; JumpD = d.j; RdD = d.rd;
    Rs1D = d.rd + 5'd10; Rs2D = d.rd + 5'd20; ALUSrcD = d.rd[0]; sel_adderD = d.j;
    qE.push_back(mk(d));
    @(posedge clk); #1;
    FlushE = 1'b0;
    e = qE.pop_front(); m = qM.pop_front(); w = qW.pop_front();
    ZeroE = e.z;
    #1;
    if (last_wv) exp_cnt++;
    chk("ValidE", {31'd0, ValidE}, {31'd0, e.ev});
    chk("PCSrcE", {31'd0, PCSrcE}, {31'd0, e.pc});
    chk("E_fields", {16'd0, ALUControlE, ResultSrcE, ALUSrcE, sel_adderE, RdE},
        {16'd0, e.alu, e.rs, e.as, e.sa, e.rd});
    chk("E_regs", {22'd0, Rs1E, Rs2E}, {22'd0, e.rs1, e.rs2});
    chk("M_stage", {22'd0, ValidM, RegWriteM, MemWriteM, ResultSrcM, RdM},
        {22'd0, m.ev, m.erw, m.emw, m.rs, m.rd});
    chk("W_stage", {23'd0, ValidW, RegWriteW, ResultSrcW, RdW},
        {23'd0, w.ev, w.erw, w.rs, w.rd});
    chk("InstRet", {28'd0, InstRet}, exp_cnt % 16);
    last_wv = w.ev;
    qM.push_back(e);
    qW.push_back(m);
  endtask

  task automatic do_reset(input bit with_flush);
    exp_t bub;
    bub = mk(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      ValidD = $urandom; RegWriteD = $urandom; MemWriteD = $urandom; JumpD = $urandom;
      BranchD = 2'($urandom); ResultSrcD = 2'($urandom); ALUControlD = 3'($urandom);
      ALUSrcD = $urandom; sel_adderD = $urandom; ZeroE = $urandom;
      Rs1D = 5'($urandom); Rs2D = 5'($urandom); RdD = 5'($urandom);
      FlushE = with_flush ? 1'b1 : 1'($urandom);
      @(posedge clk); #1;
      chk("rst_ctrl", {10'd0, ValidE, ValidM, ValidW, PCSrcE, RegWriteM, MemWriteM, RegWriteW,
          ALUControlE, ResultSrcE, ALUSrcE, sel_adderE, ResultSrcM, ResultSrcW}, 32'd0);
      chk("rst_regs", {7'd0, Rs1E, Rs2E, RdE, RdM, RdW}, 32'd0);
      chk("rst_cnt", {28'd0, InstRet}, 32'd0);
    end
    rst = 1'b0;
    qE.delete(); qM.delete(); qW.delete();
    qM.push_back(bub);
    qW.push_back(bub);
    exp_cnt = 0;
    last_wv = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t idle;
    idle = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) tbl[i] = mkv(1, 0, 1, 0, i % 4, i, 0, 0, i + 1, 0, 0);
    tbl[5]  = mkv(1, 0, 0, 0, 0, 6, 1, 0, 0, 1, 1);
    tbl[6]  = mkv(1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0);
    tbl[7]  = mkv(1, 0, 0, 0, 0, 6, 2, 0, 0, 0, 1);
    tbl[8]  = mkv(1, 0, 0, 0, 0, 6, 2, 0, 0, 1, 0);
    tbl[9]  = mkv(1, 0, 0, 0, 0, 6, 3, 0, 0, 1, 0);
    tbl[10] = mkv(1, 0, 0, 0, 0, 6, 3, 0, 0, 0, 0);
    tbl[11] = mkv(1, 0, 1, 0, 2, 0, 0, 1, 6, 0, 1);
    tbl[12] = mkv(0, 0, 1, 0, 2, 0, 0, 1, 7, 0, 0);
    tbl[13] = mkv(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[14] = mkv(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[15] = mkv(1, 1, 0, 0, 0, 6, 1, 0, 0, 1, 0);
    tbl[16] = mkv(0, 0, 0, 0, 0, 6, 1, 0, 0, 1, 0);

    rst = 1'b0; FlushE = 1'b0; ZeroE = 1'b0;
    do_reset(1'b0);

    // Straight-line ops alone first, so the retire count can be checked at 5.
    for (int i = 0; i < 5; i++) cycle(tbl[i]);
    for (int i = 0; i < 4; i++) cycle(idle);
    chk("straight_ret5", {28'd0, InstRet}, 32'd5);

    for (int i = 5; i < 17; i++) cycle(tbl[i]);
    cycle(idle);
    cycle(idle);

    // Reset with flush while instructions are still in flight.
    do_reset(1'b1);
    for (int i = 0; i < 17; i++) cycle(mkv(1, 0, 1, 0, 1, i, 0, 0, i + 1, 0, 0));
    for (int i = 0; i < 4; i++) cycle(idle);
    chk("wrap_ret17", {28'd0, InstRet}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
